// File: rtl/parity_seq_ctrl_pkg.sv
// Shared definitions for the nibble parity sequencing controller:
// FSM state encoding and default sizing.
package parity_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   localparam int DEF_MAX_NIBBLES = 8;
   localparam int DEF_CNT_W       = 4;

   // Smallest counter width able to hold max_beats without wrapping.
   function automatic int min_cnt_w(input int max_beats);
      int w;
      w = 1;
      while ((2 ** w) <= max_beats) w++;
      return w;
   endfunction

endpackage

// File: rtl/parity_seq_ctrl_xor_chain.sv
// Four-input prefix XOR chain; every tap is exposed so the same cell can
// serve partial-width parity users as well as the full-nibble parity.
module nibble_xor_chain (
   input  logic a,
   input  logic b,
   input  logic c,
   input  logic d,
   output logic p1,
   output logic p2,
   output logic p3
);

   assign p1 = a ^ b;
   assign p2 = p1 ^ c;
   assign p3 = p2 ^ d;

endmodule

// File: rtl/parity_seq_ctrl.sv
// Packet parity sequencer: folds a valid/ready stream of nibbles into one
// parity/count/overflow result per packet, presented on a valid/ready output.
module parity_seq_ctrl
   import parity_pkg::*;
#(
   parameter int MAX_NIBBLES = DEF_MAX_NIBBLES,
   parameter int CNT_W       = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             odd_mode,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_parity,
   output logic [CNT_W-1:0] out_count,
   output logic             out_overflow,
   output logic             busy
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_NIBBLES);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state_q, state_nxt;
   logic             acc_q, acc_nxt;
   logic             mode_q, mode_nxt;
   logic [CNT_W-1:0] cnt_q, cnt_nxt;
   logic             ovf_q, ovf_nxt;

   logic nib_par;
   logic tap_p1, tap_p2;
   logic unused_taps;
   logic accepting;
   logic beat;
   logic holding;

   nibble_xor_chain u_xor_chain (
      .a  (in_data[0]),
      .b  (in_data[1]),
      .c  (in_data[2]),
      .d  (in_data[3]),
      .p1 (tap_p1),
      .p2 (tap_p2),
      .p3 (nib_par)
   );

   // Only the final tap matters here; the partial taps are left for other users.
   assign unused_taps = tap_p1 ^ tap_p2;

   assign accepting = (state_q == ST_IDLE) || (state_q == ST_ACCUM);
   assign holding   = (state_q == ST_HOLD);

   // in_ready is gated by rst directly so nothing is offered while reset is held.
   assign in_ready  = accepting && !rst;
   assign beat      = in_valid && in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         acc_q   <= 1'b0;
         mode_q  <= 1'b0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_nxt;
         acc_q   <= acc_nxt;
         mode_q  <= mode_nxt;
         cnt_q   <= cnt_nxt;
         ovf_q   <= ovf_nxt;
      end
   end

   always_comb begin
      state_nxt = state_q;
      acc_nxt   = acc_q;
      mode_nxt  = mode_q;
      cnt_nxt   = cnt_q;
      ovf_nxt   = ovf_q;
      unique case (state_q)
         ST_IDLE: begin
            if (beat) begin
               acc_nxt   = nib_par;
               mode_nxt  = odd_mode;
               cnt_nxt   = CNT_ONE;
               ovf_nxt   = 1'b0;
               state_nxt = in_last ? ST_HOLD : ST_ACCUM;
            end
         end
         ST_ACCUM: begin
            if (beat) begin
               acc_nxt = acc_q ^ nib_par;
               // Count saturates; parity keeps folding past the limit.
               if (cnt_q < MAX_CNT) begin
                  cnt_nxt = cnt_q + CNT_ONE;
               end else begin
                  ovf_nxt = 1'b1;
               end
               if (in_last) begin
                  state_nxt = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            if (out_ready) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Result fields read as zero whenever no result is being offered.
   assign out_valid    = holding;
   assign out_parity   = holding ? (acc_q ^ mode_q) : 1'b0;
   assign out_count    = holding ? cnt_q : '0;
   assign out_overflow = holding ? ovf_q : 1'b0;
   assign busy         = (state_q == ST_ACCUM) || holding;

endmodule

// File: tb/tb_parity_seq_ctrl.sv
// Bench for parity_seq_ctrl: directed and randomized packets checked
// against a packet-level parity/count/overflow model.
module tb_parity_seq_ctrl;

   localparam int MAXN = 8;
   localparam int CW   = 4;

   logic          clk;
   logic          rst;
   logic          odd_mode;
   logic          in_valid;
   logic          in_ready;
   logic [3:0]    in_data;
   logic          in_last;
   logic          out_valid;
   logic          out_ready;
   logic          out_parity;
   logic [CW-1:0] out_count;
   logic          out_overflow;
   logic          busy;

   int n_assert = 0;
   int n_fail   = 0;

   logic [3:0] pkt [16];
   int         pkt_len;

   parity_seq_ctrl #(
      .MAX_NIBBLES (MAXN),
      .CNT_W       (CW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .odd_mode     (odd_mode),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .in_last      (in_last),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_parity   (out_parity),
      .out_count    (out_count),
      .out_overflow (out_overflow),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_ovalid"}, out_valid, 0);
      chk({tag, "_par"}, out_parity, 0);
      chk({tag, "_cnt"}, out_count, 0);
      chk({tag, "_ovf"}, out_overflow, 0);
   endtask

   // Sends pkt[0..pkt_len-1]; gap_len idle cycles precede beat gap_at.
   task automatic send_pkt(input logic mode, input int gap_at, input int gap_len, input int hold_cyc);
      int         ones;
      logic       exp_par;
      logic [31:0] exp_cnt;
      logic       exp_ovf;
      ones = 0;
      for (int i = 0; i < pkt_len; i++) ones += $countones(pkt[i]);
      exp_par = ones[0] ^ mode;
      exp_cnt = (pkt_len > MAXN) ? MAXN : pkt_len;
      exp_ovf = (pkt_len > MAXN);

      for (int i = 0; i < pkt_len; i++) begin
         if (i == gap_at) begin
            for (int g = 0; g < gap_len; g++) begin
               in_valid = 1'b0;
               in_data  = 4'($urandom);
               in_last  = 1'($urandom);
               odd_mode = 1'($urandom);
               step();
               chk("gap_busy", busy, 1);
               chk("gap_ovalid", out_valid, 0);
            end
         end
         in_valid = 1'b1;
         in_data  = pkt[i];
         in_last  = (i == pkt_len - 1);
         odd_mode = (i == 0) ? mode : 1'($urandom);
         chk("beat_ready", in_ready, 1);
         chk("beat_ovalid", out_valid, 0);
         step();
      end

      // Result must be up one cycle after the last beat; offered input must be refused.
      in_valid = 1'($urandom);
      in_data  = 4'($urandom);
      in_last  = 1'($urandom);
      out_ready = 1'b0;
      for (int h = 0; h <= hold_cyc; h++) begin
         chk("hold_ovalid", out_valid, 1);
         chk("hold_par", out_parity, exp_par);
         chk("hold_cnt", out_count, exp_cnt);
         chk("hold_ovf", out_overflow, exp_ovf);
         chk("hold_ready", in_ready, 0);
         chk("hold_busy", busy, 1);
         if (h < hold_cyc) step();
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      chk("post_ready", in_ready, 1);
      chk("post_busy", busy, 0);
      chk_idle_outputs("post");
   endtask

   initial begin
      rst       = 1'b1;
      odd_mode  = 1'b0;
      in_valid  = 1'b0;
      in_data   = 4'h0;
      in_last   = 1'b0;
      out_ready = 1'b0;

      @(negedge clk);
      chk("rst_ready", in_ready, 0);
      chk("rst_busy", busy, 0);
      chk_idle_outputs("rst");
      rst = 1'b0;
      @(negedge clk);
      chk("idle_ready", in_ready, 1);
      chk_idle_outputs("idle");

      // Single beat 1011 -> parity 1
      pkt[0] = 4'b1011; pkt_len = 1;
      send_pkt(1'b0, -1, 0, 0);

      // Three beats, even then odd mode
      pkt[0] = 4'h1; pkt[1] = 4'h3; pkt[2] = 4'h7; pkt_len = 3;
      send_pkt(1'b0, -1, 0, 0);
      send_pkt(1'b1, -1, 0, 0);

      // Backpressure for 5 cycles
      send_pkt(1'b0, -1, 0, 5);

      // Overflow: 10 beats of 4'h1
      for (int i = 0; i < 10; i++) pkt[i] = 4'h1;
      pkt_len = 10;
      send_pkt(1'b0, -1, 0, 1);

      // Gapped 4-beat packet
      pkt[0] = 4'h5; pkt[1] = 4'hE; pkt[2] = 4'h8; pkt[3] = 4'h3; pkt_len = 4;
      send_pkt(1'b1, 2, 3, 0);
      send_pkt(1'b1, -1, 0, 0);

      // Async reset in the middle of a packet
      in_valid = 1'b1; in_data = 4'hF; in_last = 1'b0; odd_mode = 1'b1;
      step();
      in_data = 4'h7;
      step();
      chk("pre_rst_busy", busy, 1);
      #2 rst = 1'b1;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_ready", in_ready, 0);
      chk_idle_outputs("arst");
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("rel_busy", busy, 0);
      pkt[0] = 4'h0; pkt_len = 1;
      send_pkt(1'b0, -1, 0, 0);

      // Randomized packets
      for (int p = 0; p < 40; p++) begin
         int len, gat, glen;
         len = $urandom_range(1, 12);
         for (int i = 0; i < len; i++) pkt[i] = 4'($urandom);
         pkt_len = len;
         gat  = (len > 1) ? $urandom_range(1, len - 1) : -1;
         glen = $urandom_range(0, 3);
         send_pkt(1'($urandom), gat, glen, $urandom_range(0, 3));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/parity_seq_ctrl.md
Name: parity_seq_ctrl

Overview:
- Sequencing controller for the 4-bit XOR-chain parity datapath.
- Accepts a packet of 4-bit nibbles over a valid/ready stream and folds each nibble through the XOR chain into a running parity.
- Presents one result per packet: parity bit, beat count and overflow flag, on a valid/ready output handshake.
- Sits between a nibble source (switch/FIFO front end) and a consumer such as the LED/display logic.

Parameters:
- MAX_NIBBLES, 8, maximum beats counted per packet; the count saturates here.
- CNT_W, 4, width of the beat counter; must satisfy 2**CNT_W > MAX_NIBBLES.

Ports:
- clk  input  1  single system clock; rising edge.
- rst  input  1  asynchronous, active-high reset.
- odd_mode  input  1  1 = odd parity, 0 = even parity; sampled on the first beat only.
- in_valid  input  1  source has a nibble.
- in_ready  output  1  controller accepts a nibble this cycle.
- in_data  input  4  nibble payload.
- in_last  input  1  final nibble of the packet; qualified by in_valid.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- out_parity  output  1  packet parity: XOR of all accepted bits, XOR odd_mode latched.
- out_count  output  CNT_W  beats accepted, saturating at MAX_NIBBLES.
- out_overflow  output  1  packet exceeded MAX_NIBBLES beats.
- busy  output  1  high in ACCUM or HOLD.

Behaviour:
- Reset:
  - Asynchronous, active-high. State goes to IDLE.
  - Accumulator, mode register, counter and overflow clear to 0.
  - out_valid=0, out_parity=0, out_count=0, out_overflow=0, busy=0.
  - in_ready is forced to 0 while rst is high.
- Beat: a beat is accepted when in_valid && in_ready at a rising clk edge. in_data and in_last are ignored otherwise.
- nib_par = in_data[0]^in_data[1]^in_data[2]^in_data[3], produced by the XOR-chain sub-module (final tap).
- FSM states: IDLE, ACCUM, HOLD.
- IDLE:
  - in_ready=1, out_valid=0.
  - On a beat: acc<=nib_par, mode_q<=odd_mode, count<=1, ovf<=0.
  - Next state is HOLD if in_last, else ACCUM.
- ACCUM:
  - in_ready=1.
  - On a beat: acc<=acc^nib_par.
  - If count<MAX_NIBBLES, count<=count+1. Otherwise count holds and ovf<=1 (sticky).
  - Parity keeps accumulating after overflow.
  - in_last on a beat -> HOLD.
  - No beat -> hold all registers; idle cycles inside a packet are legal.
- HOLD:
  - in_ready=0, out_valid=1.
  - out_parity=acc^mode_q, out_count=count, out_overflow=ovf.
  - All outputs stable while out_valid && !out_ready.
  - On out_ready -> IDLE.
- Latency: out_valid rises on the cycle after the edge that accepted the in_last beat.
- Throughput: minimum one bubble between packets, because in_ready=0 in HOLD and the next beat can be accepted no earlier than the first cycle in IDLE.
- odd_mode changes after the first beat have no effect on the current packet.
- Width rules:
  - out_count is unsigned CNT_W bits, range 1..MAX_NIBBLES in HOLD, and never wraps.
  - Single-beat packet (first beat with in_last) -> count=1.
- Outputs in IDLE/ACCUM: out_parity, out_count and out_overflow show 0 whenever out_valid=0.
- Reset mid-operation: any packet in progress or unacknowledged result is discarded; no partial output is produced after reset deasserts.
- Simultaneous in_valid and out_ready in HOLD: the input is not accepted; the output handshake completes.

Decomposition:
- Shared package parity_pkg:
  - State encoding constants ST_IDLE=2'd0, ST_ACCUM=2'd1, ST_HOLD=2'd2.
  - Default MAX_NIBBLES.
- One sub-module, nibble_xor_chain: combinational 4-bit prefix XOR with outputs p1=a^b, p2=p1^c, p3=p2^d. The controller uses p3 as nib_par.

Test Plan:
- Single beat: odd_mode=0, in_data=4'b1011, in_last=1 -> next cycle out_valid=1, out_parity=1, out_count=1, out_overflow=0.
- Three beats: 4'h1, 4'h3, 4'h7 (last), odd_mode=0 -> out_parity=0, out_count=3. Repeat with odd_mode=1 on beat 1 and toggled afterwards -> out_parity=1.
- Backpressure: hold out_ready=0 for 5 cycles after a result -> out_valid, out_parity and out_count stable, in_ready=0 throughout. out_ready=1 -> IDLE next cycle, in_ready=1.
- Overflow: MAX_NIBBLES=8, send 10 beats of 4'h1 with last on beat 10 -> out_count=8, out_overflow=1, out_parity=0 (10 ones, even).
- Gapped input: in_valid low for 3 cycles between beats 2 and 3 of a 4-beat packet -> same result as the ungapped packet; busy=1 throughout.
- Async reset: assert rst mid-ACCUM between clock edges -> outputs clear immediately. After release, a new 1-beat packet 4'h0 -> out_parity=0, out_count=1, with no residue from the aborted packet.
